// File: rtl/dvi_pkg.sv
// dvi_pkg: shared DVI/TMDS constants, receive-aligner state type and data-word decoder.
package dvi_pkg;
    localparam int COLOR_W = 8;
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;
    typedef enum logic {SEARCH, LOCKED} tmds_rx_state_t;
    function automatic logic [COLOR_W-1:0] tmds_decode_word(input logic [9:0] q);
        logic [7:0] dp;
        logic [7:0] d;
        dp   = q[9] ? ~q[7:0] : q[7:0];
        d[0] = dp[0];
        for (int i = 1; i < 8; i++)
            d[i] = q[8] ? dp[i] ^ dp[i-1] : ~(dp[i] ^ dp[i-1]);
        return d;
    endfunction
endpackage

// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: one TMDS sink channel; hunts the word boundary on control-token
// runs, then decodes aligned words to pixel data or C0/C1 control with DE.
module tmds_rx_channel
    import dvi_pkg::*;
#(
    parameter int LOCK_TOKENS = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [9:0]         raw_i,
    output logic [COLOR_W-1:0] data_o,
    output logic               c0_o,
    output logic               c1_o,
    output logic               de_o,
    output logic               locked_o,
    output logic [3:0]         align_offset_o
);
    localparam int RW = $clog2(LOCK_TOKENS + 1);
    localparam int TW = $clog2(TIMEOUT);
    tmds_rx_state_t     state_q, state_d;
    logic [9:0]         raw_q, word1_q, word1_d, word;
    logic [3:0]         offset_q, offset_d;
    logic [RW-1:0]      run_q, run_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               ctrl1_q, ctrl1_d, lk1_q, lk1_d;
    logic               is_ctrl, run_full, advance;
    logic [1:0]         tok_c;
    logic [COLOR_W-1:0] data_q, data_d;
    logic               c0_q, c0_d, c1_q, c1_d, de_q, de_d, locked_q, locked_d;
    logic [19:0]        window;
    always_comb begin
        window   = {raw_i, raw_q};
        word     = window[offset_q +: 10];
        is_ctrl  = word == TMDS_CTRL_00 || word == TMDS_CTRL_01 ||
                   word == TMDS_CTRL_10 || word == TMDS_CTRL_11;
        run_full = run_q == RW'(LOCK_TOKENS);
        // A completed run always outranks a simultaneous timeout.
        advance  = tmo_q == TW'(TIMEOUT - 1) && !run_full;
        state_d  = (state_q == SEARCH && run_full) ? LOCKED : advance ? SEARCH : state_q;
        offset_d = !advance ? offset_q : (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        run_d    = (advance || !is_ctrl) ? '0 : run_full ? run_q : run_q + 1'b1;
        tmo_d    = (run_full || advance) ? '0 : tmo_q + 1'b1;
        word1_d  = word;
        ctrl1_d  = is_ctrl;
        lk1_d    = state_q == LOCKED;
        tok_c    = word1_q == TMDS_CTRL_00 ? 2'b00 : word1_q == TMDS_CTRL_01 ? 2'b01 :
                   word1_q == TMDS_CTRL_10 ? 2'b10 : 2'b11;
        de_d     = lk1_q && !ctrl1_q;
        data_d   = de_d ? tmds_decode_word(word1_q) : '0;
        c0_d     = !lk1_q ? 1'b0 : ctrl1_q ? tok_c[0] : c0_q;
        c1_d     = !lk1_q ? 1'b0 : ctrl1_q ? tok_c[1] : c1_q;
        locked_d = lk1_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= SEARCH;
            raw_q    <= '0;
            offset_q <= '0;
            run_q    <= '0;
            tmo_q    <= '0;
            word1_q  <= '0;
            ctrl1_q  <= 1'b0;
            lk1_q    <= 1'b0;
            data_q   <= '0;
            c0_q     <= 1'b0;
            c1_q     <= 1'b0;
            de_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            raw_q    <= raw_i;
            offset_q <= offset_d;
            run_q    <= run_d;
            tmo_q    <= tmo_d;
            word1_q  <= word1_d;
            ctrl1_q  <= ctrl1_d;
            lk1_q    <= lk1_d;
            data_q   <= data_d;
            c0_q     <= c0_d;
            c1_q     <= c1_d;
            de_q     <= de_d;
            locked_q <= locked_d;
        end
    end
    assign data_o         = data_q;
    assign c0_o           = c0_q;
    assign c1_o           = c1_q;
    assign de_o           = de_q;
    assign locked_o       = locked_q;
    assign align_offset_o = offset_q;
endmodule

// File: tb/tb_tmds_rx_channel.sv
// tb_tmds_rx_channel: directed bench for the TMDS receive channel, with its own
// serialiser misalignment model and reference TMDS encoder.
module tb_tmds_rx_channel;
    import dvi_pkg::*;
    localparam int T = 1024;
    localparam int L = 8;
    localparam logic [9:0] K00 = 10'b1101010100;
    localparam logic [9:0] K01 = 10'b0010101011;
    localparam logic [9:0] K10 = 10'b0101010100;
    localparam logic [9:0] K11 = 10'b1010101011;
    typedef struct packed {logic de; logic [7:0] data; logic [1:0] c;} exp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   raw = '0;
    logic [7:0]   data_o;
    logic         c0_o, c1_o, de_o, locked_o;
    logic [3:0]   align_offset_o;
    int           total = 0;
    int           bad = 0;
    int           a = 0;
    int           n;
    logic [9:0]   pend = '0;
    logic [1:0]   last_c = '0;
    exp_t         q[$];
    always #5 clk = ~clk;
    tmds_rx_channel #(.LOCK_TOKENS(L), .TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst), .raw_i(raw), .data_o(data_o), .c0_o(c0_o),
        .c1_o(c1_o), .de_o(de_o), .locked_o(locked_o), .align_offset_o(align_offset_o)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
        logic [8:0] qm;
        logic       xn;
        xn    = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
    endfunction
    // Present word w so that it completes at bit offset a in the next cycle's window.
    task automatic send(input logic [9:0] w);
        logic [19:0] cat;
        cat = {w, pend};
        @(negedge clk);
        raw  = 10'(cat >> (10 - a));
        pend = w;
        @(posedge clk);
        #1;
    endtask
    task automatic send_exp(input logic [9:0] w, input logic de, input logic [7:0] d,
                            input logic [1:0] c);
        exp_t e;
        send(w);
        q.push_back({de, d, c});
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("de", de_o, e.de);
            chk("data", data_o, e.data);
            chk("c1c0", {c1_o, c0_o}, e.c);
        end
    endtask
    task automatic tok(input logic [1:0] c);
        last_c = c;
        send_exp(c == 2'd0 ? K00 : c == 2'd1 ? K01 : c == 2'd2 ? K10 : K11, 1'b0, 8'h00, c);
    endtask
    task automatic dat(input logic [7:0] v);
        send_exp(enc(v, v[0] ^ v[3]), 1'b1, v, last_c);
    endtask
    initial begin
        raw = 10'h2a5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {data_o, c1_o, c0_o, de_o, locked_o, align_offset_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        a = 3;
        n = 0;
        while (!locked_o && n < 4 * T) begin
            send(K00);
            n++;
        end
        chk("lock3", locked_o, 1);
        chk("off3", align_offset_o, 3);
        chk("lock_time", (n >= 3 * T && n <= 3 * T + L + 3), 1);
        q.delete();
        last_c = 2'd0;
        tok(2'd0);
        for (int v = 0; v < 256; v++) dat(8'(v));
        tok(2'd1);
        tok(2'd2);
        tok(2'd3);
        dat(8'ha5);
        tok(2'd2);
        dat(8'h00);
        dat(8'hff);
        tok(2'd1);
        repeat (3) tok(2'd0);
        chk("lock_hold", locked_o, 1);
        q.delete();
        n = 0;
        while (locked_o && n < T + 100) begin
            send(enc(8'(n), n[2]));
            n++;
        end
        chk("drop", locked_o, 0);
        chk("off4", align_offset_o, 4);
        a = 4;
        repeat (3) send(enc(8'h11, 1'b0));
        repeat (L - 1) send(K00);
        repeat (20) send(enc(8'h22, 1'b1));
        chk("short_run_lock", locked_o, 0);
        chk("short_run_off", align_offset_o, 4);
        repeat (L + 6) send(K00);
        chk("full_run_lock", locked_o, 1);
        chk("full_run_off", align_offset_o, 4);
        repeat (4) send(K11);
        chk("pre_rst_c", {c1_o, c0_o}, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {data_o, c1_o, c0_o, de_o, locked_o, align_offset_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        a = 9;
        n = 0;
        while (!locked_o && n < 10 * T) begin
            send(K00);
            n++;
        end
        chk("lock9", locked_o, 1);
        chk("off9", align_offset_o, 9);
        n = 0;
        while (locked_o && n < T + 100) begin
            send(enc(8'h5a, 1'b0));
            n++;
        end
        chk("wrap_drop", locked_o, 0);
        chk("wrap_off", align_offset_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
